// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative shift unit: operation codes and FSM states.
package shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/iter_shifter_shift_step.sv
// One combinational shift step of 0..STEP bits in the direction and fill given by op.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STEP   = 4,
  parameter int STEP_W = $clog2(STEP) + 1
) (
  input  logic [1:0]        op_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic [STEP_W-1:0] amt_i,
  output logic [WIDTH-1:0]  data_o
);

  logic [31:0] back_amt;

  // amt_i == 0 gives back_amt == WIDTH, which shifts the wrapped part out entirely.
  assign back_amt = 32'(WIDTH) - 32'(amt_i);

  always_comb begin
    data_o = data_i;
    case (op_i)
      OP_SLL:  data_o = data_i << amt_i;
      OP_SRL:  data_o = data_i >> amt_i;
      OP_SRA:  data_o = $signed(data_i) >>> amt_i;
      OP_ROTR: data_o = (data_i >> amt_i) | (data_i << back_amt);
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROTR unit shifting at most STEP bits per cycle,
// with valid/ready handshakes on both the request and result sides.
module iter_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int STEP    = 4,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   val,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               busy
);

  localparam int STEP_W = $clog2(STEP) + 1;
  localparam logic [SHAMT_W:0] STEP_EXT = (SHAMT_W + 1)'(STEP);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $fatal(1, "iter_shifter: WIDTH must be a power of two >= 2");
  end
  if (STEP < 1 || STEP > WIDTH || (STEP & (STEP - 1)) != 0) begin : g_bad_step
    $fatal(1, "iter_shifter: STEP must be a power of two in 1..WIDTH");
  end

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and the sender holds its payload until then.
  state_e             state_q;
  op_e                op_q;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               in_ready_q, out_valid_q, busy_q;
  logic [SHAMT_W:0]   step_wide;
  logic [STEP_W-1:0]  step;

  always_comb begin
    step_wide = {1'b0, rem_q};
    if ({1'b0, rem_q} >= STEP_EXT) step_wide = STEP_EXT;
    step  = step_wide[STEP_W-1:0];
    // step never exceeds rem_q, so the truncated subtrahend is exact.
    rem_d = rem_q - step_wide[SHAMT_W-1:0];
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .STEP_W(STEP_W)
  ) u_step (
    .op_i  (op_q),
    .data_i(acc_q),
    .amt_i (step),
    .data_o(acc_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_SLL;
      acc_q       <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            acc_q      <= val;
            rem_q      <= shamt;
            op_q       <= op_e'(op);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (shamt == '0) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          if (rem_d == '0) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = acc_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter: latency, results, backpressure and mid-op reset.
module tb_iter_shifter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] val;
  logic [4:0]   shamt;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         busy;

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  iter_shifter #(.WIDTH(32), .STEP(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .val      (val),
    .shamt    (shamt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one request and waits until out_valid is seen; leaves the DUT in DONE.
  task automatic issue_and_wait(input string tag, input logic [1:0] o, input logic [W-1:0] v,
                                input logic [4:0] s, input logic [W-1:0] exp_res,
                                input int exp_lat);
    int cyc;
    logic [W-1:0] e;
    check({tag, " in_ready_before"}, {31'b0, in_ready}, 32'd1);
    exp_q.push_back(exp_res);
    op       = o;
    val      = v;
    shamt    = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op       = 2'b00;
    val      = '0;
    shamt    = '0;
    cyc      = 1;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    // ---------------- scoreboard ----------------
    e = exp_q.pop_front();
    check({tag, " result"}, result, e);
  endtask

  // Completes the handoff with out_ready high and checks the return to IDLE.
  task automatic handoff(input string tag);
    out_ready = 1'b1;
    tick();
    check({tag, " idle_in_ready"}, {31'b0, in_ready}, 32'd1);
    check({tag, " idle_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, " idle_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = 2'b00;
    val       = '0;
    shamt     = '0;
    out_ready = 1'b1;

    tick();
    tick();
    check("rst out_valid", {31'b0, out_valid}, 32'd0);
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst result", result, 32'h0);
    rst = 1'b0;
    tick();
    check("post_rst in_ready", {31'b0, in_ready}, 32'd1);
    check("post_rst busy", {31'b0, busy}, 32'd0);

    // Main function vectors
    issue_and_wait("sll1x2", 2'b00, 32'h0000_0001, 5'd2, 32'h0000_0004, 2);
    handoff("sll1x2");
    issue_and_wait("sra31", 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9);
    handoff("sra31");
    issue_and_wait("srl31", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 9);
    handoff("srl31");
    issue_and_wait("rotr8", 2'b11, 32'h1234_5678, 5'd8, 32'h7812_3456, 3);
    handoff("rotr8");
    for (int i = 0; i < 4; i++) begin
      issue_and_wait($sformatf("zero_op%0d", i), 2'(i), 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1);
      handoff($sformatf("zero_op%0d", i));
    end
    issue_and_wait("rotr5", 2'b11, 32'h8000_0001, 5'd5, 32'h0C00_0000, 3);
    handoff("rotr5");
    issue_and_wait("sra_pos4", 2'b10, 32'h7FFF_FFF0, 5'd4, 32'h07FF_FFFF, 2);
    handoff("sra_pos4");
    issue_and_wait("sra_neg3", 2'b10, 32'hF000_0000, 5'd3, 32'hFE00_0000, 2);
    handoff("sra_neg3");
    issue_and_wait("sll31", 2'b00, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 9);
    handoff("sll31");
    issue_and_wait("srl7", 2'b01, 32'hF000_000F, 5'd7, 32'h01E0_0000, 3);
    handoff("srl7");

    // Backpressure: result held while out_ready is low; a second request is ignored
    out_ready = 1'b0;
    issue_and_wait("bp", 2'b00, 32'h0000_0001, 5'd4, 32'h0000_0010, 2);
    op       = 2'b01;
    val      = 32'hFFFF_FFFF;
    shamt    = 5'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp hold%0d result", i), result, 32'h0000_0010);
      check($sformatf("bp hold%0d out_valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("bp hold%0d in_ready", i), {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    handoff("bp");
    tick();
    check("bp no_second busy", {31'b0, busy}, 32'd0);
    check("bp no_second out_valid", {31'b0, out_valid}, 32'd0);

    // Reset in the middle of an SRA by 20
    op       = 2'b10;
    val      = 32'h8000_0000;
    shamt    = 5'd20;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("midrst busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst busy", {31'b0, busy}, 32'd0);
    check("midrst out_valid", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("midrst quiet%0d out_valid", i), {31'b0, out_valid}, 32'd0);
    end
    issue_and_wait("after_rst sra20", 2'b10, 32'h8000_0000, 5'd20, 32'hFFFF_F800, 6);
    handoff("after_rst sra20");

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iter_shifter.md
# iter_shifter

Multi-cycle, parametrised shift unit for the R-type execute path. It replaces the fixed-function left-shift-by-two with a variable-amount shifter supporting SLL, SRL, SRA and ROTR. It shifts by at most STEP bits per cycle, trading latency for area, and it uses valid/ready handshakes so the pipeline can stall around it.

## Interface
Parameters:
- WIDTH, 32, data width; must be a power of two, at least 2.
- STEP, 4, maximum bits shifted per cycle; must be a power of two, 1..WIDTH.
- SHAMT_W, $clog2(WIDTH), shift-amount width (derived; not to be overridden).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request.
- op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROTR.
- val  in  WIDTH  operand.
- shamt  in  SHAMT_W  shift amount, unsigned.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  shifted value.
- busy  out  1  high in the SHIFT and DONE states.

## Operation
- FSM states:
  - IDLE: in_ready=1, busy=0.
    - Accept when in_valid && in_ready: latch val into acc, shamt into rem, op into op_q.
    - rem==0 → DONE; else → SHIFT.
  - SHIFT: each cycle, step = min(rem, STEP).
    - acc ← acc shifted by step per op_q; rem ← rem − step.
    - Leave for DONE when the updated rem is 0.
  - DONE: out_valid=1, result=acc.
    - On out_ready → IDLE.
    - Otherwise hold acc, result and out_valid unchanged.
- Shift rules:
  - SLL fills with zeros.
  - SRL fills with zeros.
  - SRA fills with acc[WIDTH-1], sampled every step, which preserves the original sign.
  - ROTR moves bits out of the LSB into the MSB.
- in_ready=0 in SHIFT and DONE. There is no accept in the same cycle as a result handoff.
- Inputs other than in_valid are ignored outside the accept cycle.
- result is driven from acc at all times. It is only meaningful when out_valid=1.

## Timing
- Reset values:
  - state IDLE, acc 0, rem 0, op_q 00.
  - out_valid 0, result 0, busy 0.
  - in_ready 1 from the first cycle after rst deasserts.
  - While rst is asserted, outputs follow the reset state.
- Latency: request accepted in cycle 0 → out_valid first high in cycle 1 + ceil(shamt/STEP).
  - shamt=0 gives cycle 1.
- Throughput: one request per (2 + ceil(shamt/STEP)) cycles when out_ready is held high.
- Backpressure: out_valid stays high and result stays stable until out_ready is sampled high.
- Reset mid-operation, in SHIFT or DONE: the operation is discarded and no out_valid is produced. The unit is in IDLE the next cycle.
- in_valid high while in_ready=0 has no effect. The requester must hold the request until it sees in_ready.
- All outputs are registered or decoded from state only. There are no combinational input-to-output paths.

## Structure
- Package shifter_pkg holds:
  - op encodings: OP_SLL, OP_SRL, OP_SRA, OP_ROTR.
  - FSM state encodings: S_IDLE, S_SHIFT, S_DONE.
- Sub-module shift_step (purely combinational) applies one step of 0..STEP bits for a given op.
  - It is instantiated once; the FSM and registers live in iter_shifter.
- WIDTH and STEP legality is checked at elaboration. Illegal values stop the build.

## Test plan
- SLL, val=0x0000_0001, shamt=2, STEP=4 → out_valid in cycle 2, result=0x0000_0004.
- SRA, val=0x8000_0000, shamt=31 → out_valid in cycle 9, result=0xFFFF_FFFF. SRL with the same inputs → 0x0000_0001.
- ROTR, val=0x1234_5678, shamt=8 → out_valid in cycle 3, result=0x7812_3456.
- shamt=0, val=0xDEAD_BEEF, any op → out_valid in cycle 1, result=0xDEAD_BEEF.
- Backpressure: SLL 0x1 by 4 with out_ready low for 5 cycles.
  - result stays 0x10, out_valid stays 1, in_ready stays 0.
  - A second in_valid request during this time is not accepted.
  - After out_ready rises: IDLE the next cycle and in_ready=1.
- Reset mid-op: SRA shamt=20, rst pulsed in cycle 3.
  - out_valid never rises for that request; next cycle state is IDLE and in_ready=1.
  - A fresh request then completes correctly.
